immediate_field_encoder: RTL and testbench
==========================================

// Module: immediate_field_encoder
// PURPOSE
//  Multi-cycle encoder that takes a 32-bit operand and packs it into an ARM instruction
//  immediate field. It is the inverse of the immediate sign/zero extender and uses the
//  same SISE format codes and the same EN = signed convention.
//  It reports whether the value is representable and returns the packed 12-bit field.
//  The assembler/test-vector generator uses it to build instruction words.
//  Format 11 adds the data-processing rotated immediate, found by an iterative rotation search.
// PARAMETERS
//  none (formats and widths are fixed by the ARM encoding)
// PORTS
//  Clk      in   1   rising-edge clock, the only clock in the block
//  Reset_n  in   1   asynchronous, active-low reset
//  Start    in   1   request; sampled only when Busy=0
//  Value    in   32  operand to encode; captured when a request is accepted
//  SISE     in   2   format: 00 imm8, 01 imm12, 10 split imm4:imm4, 11 rotated imm8
//  EN       in   1   1 = signed (sign-extension rule), 0 = unsigned (zero rule); ignored for 11
//  Busy     out  1   request in progress
//  Done     out  1   one-cycle pulse; Fits and Field are valid from this cycle
//  Fits     out  1   1 = Value is representable in the selected format
//  Field    out  12  packed immediate field
// BEHAVIOUR
//  Reset:
//   - Reset_n=0 asynchronously clears: state=IDLE, Busy=0, Done=0, Fits=0, Field=0, rot=0.
//   - A request in flight when reset asserts is discarded.
//  States:
//   - IDLE: Start=1 at a rising edge E0 latches Value, SISE and EN.
//     The next state is CHECK for SISE 00/01/10, or SEARCH with rot=0 for SISE 11. Busy=1.
//   - CHECK: at E1, register Fits and Field, set Done=1 and Busy=0, return to IDLE.
//   - SEARCH: each cycle test rot (0..15). The candidate is c = Value ROL (2*rot).
//     * If c[31:8]==0: Fits=1, Field={rot[3:0],c[7:0]}, Done=1, go to IDLE.
//       The smallest matching rot wins.
//     * Else if rot==15: Fits=0, Field=0, Done=1, go to IDLE.
//     * Else rot=rot+1.
//  Output register rules:
//   - Done is high for exactly one cycle and clears at the next edge.
//   - Busy is low in the Done cycle.
//   - Fits and Field hold their values until the next Done.
//  Latency, counted from the accepting edge E0:
//   - SISE 00/01/10: Done rises at E1.
//   - SISE 11: Done rises at E(k+1) on a match at rot=k.
//   - SISE 11 with no match: Done rises at E16.
//  Representability tests (latched operand v):
//   - 00: EN=1 requires v==sext(v[7:0]); EN=0 requires v[31:8]==0. Field={4'h0,v[7:0]}.
//   - 01: EN=1 requires v==sext(v[11:0]); EN=0 requires v[31:12]==0. Field=v[11:0].
//   - 10: same 8-bit test as 00. Field={v[7:4],4'h0,v[3:0]}, i.e. hi nibble in [11:8], lo nibble in [3:0].
//  On Fits=0 (any format): Field=0.
//  Handshake and boundary cases:
//   - Start while Busy=1 is ignored and does not alter the latched operand.
//   - Start=1 in the Done cycle (state IDLE) is accepted.
//     Back-to-back requests therefore have no idle gap.
//   - Value and SISE may change freely after acceptance.
//   - Value=0 in format 11 gives rot=0, Field=0, Fits=1.
// TESTING
//  1. SISE=00, EN=1:
//     - 0xFFFFFF80 -> Done at E1, Fits=1, Field=0x080.
//     - 0x00000080 -> Fits=0, Field=0.
//     - 0x00000080 with EN=0 -> Fits=1, Field=0x080.
//  2. SISE=01:
//     - EN=0, 0x00000ABC -> Fits=1, Field=0xABC.
//     - EN=0, 0x00001000 -> Fits=0.
//     - EN=1, 0xFFFFF800 -> Fits=1, Field=0x800.
//  3. SISE=10, EN=0:
//     - 0x000000A5 -> Field=0xA05, Fits=1.
//     - 0x00000100 -> Fits=0.
//  4. SISE=11:
//     - 0x000000FF -> Done at E1, Field=0x0FF.
//     - 0xFF000000 -> Done at E5, Field=0x4FF.
//     - 0x00000101 -> Done at E16, Fits=0, Field=0.
//  5. During a SISE=11 search of 0x00000101:
//     - Pulse Start with 0x000000FF -> ignored; the result is still Fits=0 at E16.
//     - Drop Reset_n at E8 -> Busy/Done/Fits/Field=0 immediately.
//     - New Start after release behaves normally.
//  6. Assert Start in the Done cycle with SISE=00, Value=0x7F:
//     - Accepted; next Done one cycle later with Field=0x07F.
//     - Busy high for exactly one cycle in between.

Source files
------------

// File: rtl/immediate_field_encoder.sv
// ---------------------------------------------------------------------------
// immediate_field_encoder
//   Packs a 32-bit operand into a 12-bit ARM instruction immediate field and
//   reports whether the operand is representable in the selected format.
//   Formats (SISE): 00 imm8, 01 imm12, 10 split imm4:imm4, 11 rotated imm8.
//   EN selects the signed (sign-extension) or unsigned (zero) rule. EN is
//   ignored for the rotated format.
//   The rotated format is solved by a one-rotation-per-cycle search, so its
//   latency ranges from 1 to 16 cycles. All other formats take 1 cycle.
//
// Ports
//   Clk      in   1   rising-edge clock
//   Reset_n  in   1   asynchronous active-low reset
//   Start    in   1   request, sampled only while idle
//   Value    in   32  operand, captured when a request is accepted
//   SISE     in   2   format select
//   EN       in   1   1 = signed rule, 0 = unsigned rule
//   Busy     out  1   request in progress
//   Done     out  1   one-cycle completion pulse
//   Fits     out  1   operand representable (held until next Done)
//   Field    out  12  packed immediate, zero when Fits=0 (held until next Done)
// ---------------------------------------------------------------------------
module immediate_field_encoder (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [31:0] Value,
  input  logic [1:0]  SISE,
  input  logic        EN,
  output logic        Busy,
  output logic        Done,
  output logic        Fits,
  output logic [11:0] Field
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] SEARCH = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_val;
  logic [1:0]  r_sise;
  logic        r_en;
  logic [3:0]  r_rot;
  logic        r_busy;
  logic        r_done;
  logic        r_fits;
  logic [11:0] r_field;

  // Fixed-format (00/01/10) representability and packing.
  logic        w_fit8;
  logic        w_fit12;
  logic        w_fix_fits;
  logic [11:0] w_fix_field;

  always_comb begin
    w_fit8      = 1'b0;
    w_fit12     = 1'b0;
    w_fix_fits  = 1'b0;
    w_fix_field = 12'h000;
    if (r_en) begin
      w_fit8  = (r_val == {{24{r_val[7]}},  r_val[7:0]});
      w_fit12 = (r_val == {{20{r_val[11]}}, r_val[11:0]});
    end else begin
      w_fit8  = (r_val[31:8]  == 24'h0);
      w_fit12 = (r_val[31:12] == 20'h0);
    end
    case (r_sise)
      2'b00: begin
        w_fix_fits  = w_fit8;
        w_fix_field = {4'h0, r_val[7:0]};
      end
      2'b01: begin
        w_fix_fits  = w_fit12;
        w_fix_field = r_val[11:0];
      end
      2'b10: begin
        w_fix_fits  = w_fit8;
        w_fix_field = {r_val[7:4], 4'h0, r_val[3:0]};
      end
      default: begin
        w_fix_fits  = 1'b0;
        w_fix_field = 12'h000;
      end
    endcase
  end

  // Rotated-format candidate: operand rotated left by 2*rot. With rot=0 the
  // right shift is by 32, which yields zero and leaves the plain operand.
  logic [4:0]  w_sh;
  logic [31:0] w_cand;
  logic        w_cand_hit;

  assign w_sh       = {r_rot, 1'b0};
  assign w_cand     = (r_val << w_sh) | (r_val >> (6'd32 - {1'b0, w_sh}));
  assign w_cand_hit = (w_cand[31:8] == 24'h0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_val   <= 32'h0;
      r_sise  <= 2'b00;
      r_en    <= 1'b0;
      r_rot   <= 4'h0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fits  <= 1'b0;
      r_field <= 12'h000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Also reached in the Done cycle, so back-to-back requests are
          // accepted without an idle gap.
          if (Start) begin
            r_val   <= Value;
            r_sise  <= SISE;
            r_en    <= EN;
            r_rot   <= 4'h0;
            r_busy  <= 1'b1;
            r_state <= (SISE == 2'b11) ? SEARCH : CHECK;
          end
        end
        CHECK: begin
          r_fits  <= w_fix_fits;
          r_field <= w_fix_fits ? w_fix_field : 12'h000;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        SEARCH: begin
          // Smallest matching rotation wins because rot counts upward.
          if (w_cand_hit) begin
            r_fits  <= 1'b1;
            r_field <= {r_rot, w_cand[7:0]};
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_rot == 4'hF) begin
            r_fits  <= 1'b0;
            r_field <= 12'h000;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_rot <= r_rot + 4'h1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Busy  = r_busy;
  assign Done  = r_done;
  assign Fits  = r_fits;
  assign Field = r_field;

endmodule

// File: tb/tb_immediate_field_encoder.sv
module tb_immediate_field_encoder;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [31:0] Value;
  logic [1:0]  SISE;
  logic        EN;
  logic        Busy;
  logic        Done;
  logic        Fits;
  logic [11:0] Field;

  int n_checks = 0;
  int n_fail   = 0;

  immediate_field_encoder dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Value(Value), .SISE(SISE),
    .EN(EN), .Busy(Busy), .Done(Done), .Fits(Fits), .Field(Field)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: range tests in plain arithmetic, exhaustive rotation scan.
  function automatic void model(input logic [31:0] v, input logic [1:0] s, input logic e,
                                output logic f, output logic [11:0] fld, output int lat);
    longint sv;
    logic [31:0] c;
    sv  = longint'($signed(v));
    f   = 1'b0;
    fld = 12'h000;
    lat = 1;
    case (s)
      2'd0, 2'd2: begin
        f = e ? (sv >= -128 && sv <= 127) : (v < 32'd256);
        if (f) fld = (s == 2'd0) ? 12'(v & 32'hFF) : 12'((((v >> 4) & 32'hF) << 8) | (v & 32'hF));
      end
      2'd1: begin
        f = e ? (sv >= -2048 && sv <= 2047) : (v < 32'd4096);
        if (f) fld = 12'(v & 32'hFFF);
      end
      default: begin
        lat = 16;
        for (int k = 0; k < 16; k++) begin
          c = (k == 0) ? v : ((v << (2*k)) | (v >> (32 - 2*k)));
          if (c < 32'd256) begin
            f = 1'b1; fld = 12'(k * 256 + int'(c)); lat = k + 1;
            break;
          end
        end
      end
    endcase
  endfunction

  // Called at a negedge with the DUT idle (or in its Done cycle). Returns at the
  // negedge of the Done cycle, or after 40 cycles with lat=-1.
  task automatic run_req(input logic [31:0] v, input logic [1:0] s, input logic e,
                         output int lat, output logic f, output logic [11:0] fld,
                         output bit busy_ok);
    Value = v; SISE = s; EN = e; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    Value = $urandom; SISE = 2'($urandom); EN = 1'($urandom);
    lat = -1; f = 1'b0; fld = 12'h000; busy_ok = Busy;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clk);
      if (Done) begin
        lat = n; f = Fits; fld = Field;
        if (Busy) busy_ok = 1'b0;
        break;
      end else if (!Busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Start = 1'b0; Value = 32'h0; SISE = 2'b00; EN = 1'b0;
    #12;
    if ({Busy, Done, Fits, Field} !== 15'h0) begin
      n_fail++; $display("FAIL reset_outputs got %h exp 0", {Busy, Done, Fits, Field});
    end
    n_checks++;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  typedef struct {
    logic [31:0] v; logic [1:0] s; logic e; int lat; logic f; logic [11:0] fld;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[12];
    int lat; logic f; logic [11:0] fld; bit bok;
    tbl[0]  = '{32'hFFFFFF80, 2'd0, 1'b1, 1,  1'b1, 12'h080};
    tbl[1]  = '{32'h00000080, 2'd0, 1'b1, 1,  1'b0, 12'h000};
    tbl[2]  = '{32'h00000080, 2'd0, 1'b0, 1,  1'b1, 12'h080};
    tbl[3]  = '{32'h00000ABC, 2'd1, 1'b0, 1,  1'b1, 12'hABC};
    tbl[4]  = '{32'h00001000, 2'd1, 1'b0, 1,  1'b0, 12'h000};
    tbl[5]  = '{32'hFFFFF800, 2'd1, 1'b1, 1,  1'b1, 12'h800};
    tbl[6]  = '{32'h000000A5, 2'd2, 1'b0, 1,  1'b1, 12'hA05};
    tbl[7]  = '{32'h00000100, 2'd2, 1'b0, 1,  1'b0, 12'h000};
    tbl[8]  = '{32'h000000FF, 2'd3, 1'b1, 1,  1'b1, 12'h0FF};
    tbl[9]  = '{32'hFF000000, 2'd3, 1'b0, 5,  1'b1, 12'h4FF};
    tbl[10] = '{32'h00000101, 2'd3, 1'b0, 16, 1'b0, 12'h000};
    tbl[11] = '{32'h00000000, 2'd3, 1'b1, 1,  1'b1, 12'h000};
    for (int i = 0; i < 12; i++) begin
      run_req(tbl[i].v, tbl[i].s, tbl[i].e, lat, f, fld, bok);
      if (lat !== tbl[i].lat) begin
        n_fail++; $display("FAIL dir%0d latency got %0d exp %0d", i, lat, tbl[i].lat);
      end
      n_checks++;
      if (f !== tbl[i].f) begin
        n_fail++; $display("FAIL dir%0d fits got %b exp %b", i, f, tbl[i].f);
      end
      n_checks++;
      if (fld !== tbl[i].fld) begin
        n_fail++; $display("FAIL dir%0d field got %h exp %h", i, fld, tbl[i].fld);
      end
      n_checks++;
      if (!bok) begin
        n_fail++; $display("FAIL dir%0d busy got bad exp high-until-done", i);
      end
      n_checks++;
      @(negedge Clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] v; logic [1:0] s; logic e;
    logic ef; logic [11:0] efld; int elat;
    int lat; logic f; logic [11:0] fld; bit bok;
    for (int i = 0; i < 60; i++) begin
      s = 2'($urandom); e = 1'($urandom);
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = $urandom_range(0, 4095);
        2: v = 32'hFFFFFFFF - $urandom_range(0, 4095);
        default: begin
          v = $urandom_range(0, 255);
          for (int r = 0; r < int'($urandom_range(0, 15)); r++) v = {v[1:0], v[31:2]};
        end
      endcase
      model(v, s, e, ef, efld, elat);
      run_req(v, s, e, lat, f, fld, bok);
      if (lat !== elat || f !== ef || fld !== efld || !bok) begin
        n_fail++;
        $display("FAIL rnd%0d v=%h s=%0d e=%b got lat=%0d fits=%b field=%h busy_ok=%b exp lat=%0d fits=%b field=%h",
                 i, v, s, e, lat, f, fld, bok, elat, ef, efld);
      end
      n_checks++;
      if ($urandom_range(0, 1) == 1) @(negedge Clk);
    end
    @(negedge Clk);
  endtask

  task automatic test_busy_ignore();
    int lat = -1;
    Value = 32'h00000101; SISE = 2'd3; EN = 1'b0; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clk);
      if (Done) begin lat = n; break; end
      if (n == 3) begin Start = 1'b1; Value = 32'h000000FF; SISE = 2'd0; end
      if (n == 4) Start = 1'b0;
    end
    if (lat !== 16 || Fits !== 1'b0 || Field !== 12'h000) begin
      n_fail++; $display("FAIL busy_ignore got lat=%0d fits=%b field=%h exp lat=16 fits=0 field=000", lat, Fits, Field);
    end
    n_checks++;
    @(negedge Clk);
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL busy_ignore_after got busy=%b done=%b exp 0 0", Busy, Done);
    end
    n_checks++;
  endtask

  task automatic test_reset_midsearch();
    int lat; logic f; logic [11:0] fld; bit bok;
    run_req(32'h000000FF, 2'd3, 1'b0, lat, f, fld, bok);  // leave Fits=1, Field nonzero
    @(negedge Clk);
    Value = 32'h00000101; SISE = 2'd3; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (7) @(negedge Clk);
    @(posedge Clk);  // E8
    #2 Reset_n = 1'b0;
    #1;
    if ({Busy, Done, Fits, Field} !== 15'h0) begin
      n_fail++; $display("FAIL reset_mid got %h exp 0", {Busy, Done, Fits, Field});
    end
    n_checks++;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    run_req(32'hFF000000, 2'd3, 1'b0, lat, f, fld, bok);
    if (lat !== 5 || f !== 1'b1 || fld !== 12'h4FF || !bok) begin
      n_fail++; $display("FAIL post_reset got lat=%0d fits=%b field=%h exp lat=5 fits=1 field=4FF", lat, f, fld);
    end
    n_checks++;
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    int lat; logic f; logic [11:0] fld; bit bok;
    run_req(32'h00000401, 2'd1, 1'b0, lat, f, fld, bok);
    if (lat !== 1 || fld !== 12'h401) begin
      n_fail++; $display("FAIL b2b_first got lat=%0d field=%h exp lat=1 field=401", lat, fld);
    end
    n_checks++;
    // Now in the Done cycle: issue the next request immediately.
    Value = 32'h0000007F; SISE = 2'd0; EN = 1'b1; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap got busy=%b done=%b exp 1 0", Busy, Done);
    end
    n_checks++;
    @(negedge Clk);
    if (Done !== 1'b1 || Busy !== 1'b0 || Fits !== 1'b1 || Field !== 12'h07F) begin
      n_fail++; $display("FAIL b2b_second got done=%b busy=%b fits=%b field=%h exp 1 0 1 07F", Done, Busy, Fits, Field);
    end
    n_checks++;
    @(negedge Clk);
    if (Done !== 1'b0 || Busy !== 1'b0 || Field !== 12'h07F) begin
      n_fail++; $display("FAIL b2b_pulse got done=%b busy=%b field=%h exp 0 0 07F", Done, Busy, Field);
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_midsearch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
